// File: rtl/vram_scheduler.sv
// Video RAM scheduler: one display fetch per pixel period during active video,
// with buffered writer traffic drained into the remaining single-port RAM cycles.
module vram_scheduler #(
  parameter int unsigned FB_W       = 160,
  parameter int unsigned SCALE_SH   = 2,
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_tick,
  input  logic              video_on,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] rgb,
  output logic              hsync,
  output logic              vsync,
  output logic [2:0]        fifo_level
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W = 3;

  typedef enum logic [1:0] {
    PH_FETCH   = 2'd0,
    PH_CAPTURE = 2'd1,
    PH_FREE    = 2'd2,
    PH_IDLE    = 2'd3
  } phase_e;

  phase_e            phase_q, phase_d;
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  count_q, count_d;
  logic              wr_ready_q, wr_ready_d;
  logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              rd_q;
  logic [DATA_W-1:0] rgb_q, rgb_d;
  logic [1:0]        hs_q, vs_q;

  logic [ADDR_W-1:0] x_word, y_word, row_base, fetch_addr;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              push, pop, fetch, slot_ok, avail;

  assign x_word = ADDR_W'(pixel_x >> SCALE_SH);
  assign y_word = ADDR_W'(pixel_y >> SCALE_SH);

  // Row base y*FB_W; the 160-word case is a shift-add, truncated to ADDR_W.
  if (FB_W == 160) begin : g_row160
    assign row_base = (y_word << 7) + (y_word << 5);
  end else begin : g_rowmul
    assign row_base = y_word * ADDR_W'(FB_W);
  end

  assign fetch_addr = row_base + x_word;

  always_comb begin
    phase_d     = phase_q;
    push        = wr_valid && wr_ready_q;
    avail       = (count_q != '0) || push;
    head_addr   = wr_addr;
    head_data   = wr_data;
    fetch       = 1'b0;
    slot_ok     = 1'b0;
    pop         = 1'b0;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    rgb_d       = rgb_q;

    if (p_tick) begin
      phase_d = PH_FETCH;
    end else begin
      case (phase_q)
        PH_FETCH:   phase_d = PH_CAPTURE;
        PH_CAPTURE: phase_d = PH_FREE;
        default:    phase_d = PH_IDLE;
      endcase
    end

    // Head of queue, or the word arriving now when the FIFO is empty.
    if (count_q != '0) begin
      head_addr = fifo_addr_q[rd_ptr_q];
      head_data = fifo_data_q[rd_ptr_q];
    end

    // Access for the coming cycle: fetch owns phases 0/1 during active video.
    fetch   = (phase_d == PH_FETCH) && video_on;
    slot_ok = !(((phase_d == PH_FETCH) || (phase_d == PH_CAPTURE)) && video_on);
    pop     = slot_ok && avail;

    if (fetch) begin
      ram_en_d   = 1'b1;
      ram_addr_d = fetch_addr;
    end else if (pop) begin
      ram_en_d    = 1'b1;
      ram_we_d    = 1'b1;
      ram_addr_d  = head_addr;
      ram_wdata_d = head_data;
    end

    if (phase_q == PH_CAPTURE) begin
      rgb_d = rd_q ? ram_rdata : '0;
    end

    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + LVL_W'(push) - LVL_W'(pop);
    wr_ready_d = (count_d != LVL_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q     <= PH_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ready_q  <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rd_q        <= 1'b0;
      rgb_q       <= '0;
      hs_q        <= '0;
      vs_q        <= '0;
    end else begin
      phase_q     <= phase_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ready_q  <= wr_ready_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rd_q        <= ram_en_q && !ram_we_q;
      rgb_q       <= rgb_d;
      hs_q        <= {hs_q[0], hsync_in};
      vs_q        <= {vs_q[0], vsync_in};
    end
  end

  // Payload storage needs no reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= wr_addr;
      fifo_data_q[wr_ptr_q] <= wr_data;
    end
  end

  assign wr_ready   = wr_ready_q;
  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign rgb        = rgb_q;
  assign hsync      = hs_q[1];
  assign vsync      = vs_q[1];
  assign fifo_level = count_q;

endmodule

// File: tb/tb_vram_scheduler.sv
// Bench for vram_scheduler: directed opening sequence then randomized traffic,
// all checked cycle by cycle against a queue-based behavioural model.
module tb_vram_scheduler;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned FB_W   = 160;
  localparam int unsigned SCALE  = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int          N_CYC  = 3000;

  logic              clk, reset, p_tick, video_on, hsync_in, vsync_in, wr_valid;
  logic              wr_ready, ram_en, ram_we, hsync, vsync;
  logic [9:0]        pixel_x, pixel_y;
  logic [ADDR_W-1:0] wr_addr, ram_addr;
  logic [DATA_W-1:0] wr_data, ram_wdata, ram_rdata, rgb;
  logic [2:0]        fifo_level;

  vram_scheduler dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .rgb(rgb), .hsync(hsync), .vsync(vsync),
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, scyc = 0, since_tick = 0;
  bit rst1_done = 0, rst2_done = 0;
  logic saw_full = 1'b0;

  // Reference model: pending writes, pixel-period phase and latched period inputs.
  wr_t               m_q[$];
  int                m_phase = 3;
  logic              m_vid = 1'b0, m_rd_prev = 1'b0;
  logic [9:0]        m_x = '0, m_y = '0;
  logic [DATA_W-1:0] m_rgb = '0;
  logic [1:0]        sync_hist [0:4095];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_eq("rst_ram_en", 32'(ram_en), 32'(0));
    check_eq("rst_ram_we", 32'(ram_we), 32'(0));
    check_eq("rst_rgb", 32'(rgb), 32'(0));
    check_eq("rst_level", 32'(fifo_level), 32'(0));
    check_eq("rst_hsync", 32'(hsync), 32'(0));
    check_eq("rst_vsync", 32'(vsync), 32'(0));
    check_eq("rst_wr_ready", 32'(wr_ready), 32'(0));
    p_tick = 1'b0; wr_valid = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    video_on = 1'b0; pixel_x = '0; pixel_y = '0;
    wr_addr = '0; wr_data = '0; ram_rdata = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    m_q.delete();
    m_phase = 3; m_vid = 1'b0; m_rd_prev = 1'b0; m_rgb = '0;
    m_x = '0; m_y = '0; scyc = 0; since_tick = 0;
  endtask

  task automatic step();
    logic              exp_rd, exp_wr, tick;
    wr_t               w, nw;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        sh;
    int                seg;

    // Expected RAM activity for this cycle.
    exp_rd  = (m_phase == 0) && m_vid;
    exp_wr  = 1'b0;
    w       = '0;
    if (!((m_phase <= 1) && m_vid) && (m_q.size() > 0)) begin
      exp_wr = 1'b1;
      w      = m_q.pop_front();
    end
    rd_addr = ADDR_W'((int'(m_y) / SCALE) * FB_W + int'(m_x) / SCALE);
    sh      = (scyc >= 2) ? sync_hist[(scyc - 2) % 4096] : 2'b00;

    check_eq("ram_en", 32'(ram_en), 32'(exp_rd | exp_wr));
    check_eq("ram_we", 32'(ram_we), 32'(exp_wr));
    if (exp_rd) check_eq("rd_addr", 32'(ram_addr), 32'(rd_addr));
    if (exp_wr) begin
      check_eq("wr_addr", 32'(ram_addr), 32'(w.addr));
      check_eq("wr_data", 32'(ram_wdata), 32'(w.data));
    end
    check_eq("rgb", 32'(rgb), 32'(m_rgb));
    check_eq("hsync", 32'(hsync), 32'(sh[1]));
    check_eq("vsync", 32'(vsync), 32'(sh[0]));
    check_eq("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    check_eq("wr_ready", 32'(wr_ready), 32'(m_q.size() < DEPTH));
    if (!wr_ready && (fifo_level == 3'd4)) saw_full = 1'b1;

    case (cyc)
      2: begin
        check_eq("fetch_addr_323", 32'(ram_addr), 32'd323);
        check_eq("fetch_is_read", 32'(ram_we), 32'(0));
      end
      3: check_eq("hsync_pre_edge", 32'(hsync), 32'(0));
      4: begin
        check_eq("hsync_with_rgb", 32'(hsync), 32'(1));
        check_eq("rgb_a5", 32'(rgb), 32'hA5);
      end
      5, 6, 7: check_eq("rgb_a5_hold", 32'(rgb), 32'hA5);
      11: begin
        check_eq("blank_wr_we", 32'(ram_we), 32'(1));
        check_eq("blank_wr_addr", 32'(ram_addr), 32'd100);
        check_eq("blank_wr_data", 32'(ram_wdata), 32'h3C);
      end
      12: check_eq("blank_rgb_black", 32'(rgb), 32'(0));
      default: ;
    endcase

    // Stimulus for this cycle.
    if (cyc < 24) begin
      tick      = (cyc % 4 == 1);
      video_on  = (cyc < 9) || (cyc >= 17);
      pixel_x   = 10'd13;
      pixel_y   = 10'd9;
      hsync_in  = (cyc >= 2) && (cyc < 14);
      vsync_in  = 1'b0;
      ram_rdata = (cyc == 3) ? 8'hA5 : (cyc == 7) ? 8'hC3 : 8'($urandom);
      wr_valid  = (cyc == 10) || (cyc >= 16);
      wr_addr   = (cyc == 10) ? 15'd100 : 15'($urandom);
      wr_data   = (cyc == 10) ? 8'h3C : 8'($urandom);
    end else begin
      seg  = (cyc / 256) % 4;
      tick = (since_tick == 3) || ($urandom_range(0, 31) == 0);
      if (tick) begin
        if (seg == 1)      video_on = 1'b0;
        else if (seg == 2) video_on = 1'b1;
        else               video_on = ($urandom_range(0, 99) < ((seg == 0) ? 90 : 50));
        pixel_x = 10'($urandom);
        pixel_y = 10'($urandom);
      end
      if ($urandom_range(0, 7) == 0)  hsync_in = ~hsync_in;
      if ($urandom_range(0, 15) == 0) vsync_in = ~vsync_in;
      ram_rdata = 8'($urandom);
      case (seg)
        0:       wr_valid = ($urandom_range(0, 99) < 50);
        1:       wr_valid = ($urandom_range(0, 99) < 70);
        2:       wr_valid = ($urandom_range(0, 99) < 90);
        default: wr_valid = ($urandom_range(0, 99) < 20);
      endcase
      wr_addr = 15'($urandom);
      wr_data = 8'($urandom);
    end
    p_tick = tick;

    // Advance the model by one clock.
    if (wr_valid && (m_q.size() < DEPTH)) begin
      nw.addr = wr_addr;
      nw.data = wr_data;
      m_q.push_back(nw);
    end
    if (m_phase == 1) m_rgb = m_rd_prev ? ram_rdata : '0;
    m_rd_prev = exp_rd;
    sync_hist[scyc % 4096] = {hsync_in, vsync_in};
    if (tick) begin
      m_vid = video_on;
      m_x   = pixel_x;
      m_y   = pixel_y;
    end
    m_phase    = tick ? 0 : ((m_phase < 3) ? m_phase + 1 : 3);
    since_tick = tick ? 0 : since_tick + 1;
    cyc++;
    scyc++;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; p_tick = 1'b0; video_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    wr_valid = 1'b0; pixel_x = '0; pixel_y = '0; wr_addr = '0; wr_data = '0; ram_rdata = '0;
    #2;
    do_reset();
    while (cyc < N_CYC) begin
      if (!rst1_done && (cyc >= 900) && ((m_q.size() == 3) || (cyc >= 1400))) begin
        rst1_done = 1;
        do_reset();
      end else if (!rst2_done && (cyc >= 2200)) begin
        rst2_done = 1;
        do_reset();
      end else begin
        step();
      end
    end
    check_eq("fifo_full_seen", 32'(saw_full), 32'(1));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
